// File: rtl/uart_tx_io.sv
// uart_tx_io: memory-mapped 8N1 UART transmitter with a small byte FIFO.
// Optional even parity bit when UART_PARITY_EN is defined.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   reset      synchronous active-low reset
//   writedata  store data; [31]=0 data push, [31]=1 control
//   WE         write strobe from the address decoder
//   RD         status: [0] empty [1] full [2] busy [3] overflow
//              [4] parity present, [8 +: FIFO_AW+1] count
//   tx         serial line, registered, idle high
module uart_tx_io #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_AW      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] writedata,
  input  logic        WE,
  output logic [31:0] RD,
  output logic        tx
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BW    = $clog2(CLKS_PER_BIT);

  localparam logic [BW-1:0] BAUD_MAX =
    BW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] FULL_CNT =
    {1'b1, {FIFO_AW{1'b0}}};

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  // FIFO state
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, wptr_d;
  logic [FIFO_AW-1:0] rptr_q, rptr_d;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  // Serialiser state
  state_t        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q;
  logic          tx_q;
`ifdef UART_PARITY_EN
  logic          par_q;
`endif

  logic       empty, full;
  logic       baud_end;
  logic       pop, push;
  logic       data_wr, ctrl_wr;
  logic [7:0] head;
  logic       unused_wd;

  assign unused_wd = ^writedata[30:8];

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == FULL_CNT);
  assign baud_end = (baud_q == BAUD_MAX);
  assign head     = mem_q[rptr_q];

  assign data_wr = WE & ~writedata[31];
  assign ctrl_wr = WE &  writedata[31];

  // The serialiser takes a byte when idle, or at the last
  // stop-bit cycle so frames run back to back.
  assign pop = ~empty &
    ((state_q == IDLE) |
     ((state_q == STOP) & baud_end));

  // A pop at the same edge frees a slot for a full FIFO.
  assign push = data_wr & (~full | pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (ctrl_wr && writedata[0])
      ovf_d = 1'b0;
    else if (data_wr && full && !pop)
      ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  // Storage needs no reset: the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= writedata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
`ifdef UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          baud_q <= '0;
          if (pop) begin
            sh_q    <= head;
`ifdef UART_PARITY_EN
            par_q   <= ^head;
`endif
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= sh_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
              tx_q    <= par_q;
              state_q <= PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= STOP;
`endif
            end else begin
              bit_q <= bit_q + 1'b1;
              sh_q  <= {1'b0, sh_q[7:1]};
              tx_q  <= sh_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (baud_end) begin
            baud_q  <= '0;
            tx_q    <= 1'b1;
            state_q <= STOP;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_end) begin
            baud_q <= '0;
            if (pop) begin
              sh_q    <= head;
`ifdef UART_PARITY_EN
              par_q   <= ^head;
`endif
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          baud_q  <= '0;
          tx_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx = tx_q;

  always_comb begin
    RD                 = '0;
    RD[0]              = empty;
    RD[1]              = full;
    RD[2]              = (state_q != IDLE);
    RD[3]              = ovf_q;
`ifdef UART_PARITY_EN
    RD[4]              = 1'b1;
`endif
    RD[8 +: FIFO_AW+1] = cnt_q;
  end

endmodule

// File: tb/tb_uart_tx_io.sv
// tb_uart_tx_io: directed bench for uart_tx_io with a frame-level
// model compared every cycle plus literal spot checks.
module tb_uart_tx_io;

  localparam int CPB   = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
  localparam logic [10:0] PAT55 = 11'b1_0_01010101_0;
`else
  localparam int NB = 10;
  localparam logic [10:0] PAT55 = 11'b0_1_01010101_0;
`endif
  localparam int FL = NB * CPB;

  logic        clk;
  logic        reset;
  logic [31:0] writedata;
  logic        WE;
  logic [31:0] RD;
  logic        tx;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  uart_tx_io #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clk(clk), .reset(reset), .writedata(writedata),
    .WE(WE), .RD(RD), .tx(tx)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Frame-level model: a byte queue and the frame on the line
  logic [7:0]  q[$];
  bit          m_ovf, m_act;
  int          m_pos;
  logic [10:0] m_frame;

  function automatic logic [10:0] mkframe(input logic [7:0] b);
`ifdef UART_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b0, 1'b1, b, 1'b0};
`endif
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      q.delete();
      m_ovf = 0;
      m_act = 0;
      m_pos = 0;
    end else begin
      bit fend, popit;
      fend  = m_act && (m_pos == FL - 1);
      popit = (q.size() != 0) && (!m_act || fend);
      if (popit) begin
        m_frame = mkframe(q.pop_front());
        m_act = 1;
        m_pos = 0;
      end else if (fend) begin
        m_act = 0;
      end else if (m_act) begin
        m_pos++;
      end
      if (WE) begin
        if (writedata[31]) begin
          if (writedata[0]) m_ovf = 0;
        end else if (q.size() < DEPTH) begin
          q.push_back(writedata[7:0]);
        end else begin
          m_ovf = 1;
        end
      end
    end
  end

  function automatic logic exp_tx();
    return m_act ? m_frame[m_pos / CPB] : 1'b1;
  endfunction

  function automatic logic [31:0] exp_rd();
    logic [31:0] r;
    r = '0;
    r[0] = (q.size() == 0);
    r[1] = (q.size() == DEPTH);
    r[2] = m_act;
    r[3] = m_ovf;
`ifdef UART_PARITY_EN
    r[4] = 1'b1;
`endif
    r[8 +: 3] = 3'(q.size());
    return r;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_tx", {31'b0, tx}, {31'b0, exp_tx()});
      chk("model_RD", RD, exp_rd());
    end
  end

  task automatic wr(input logic [31:0] d);
    @(negedge clk);
    writedata = d;
    WE = 1;
    @(negedge clk);
    WE = 0;
  endtask

  logic [31:0] bv[6];

  task automatic burst(input int n);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      writedata = bv[i];
      WE = 1;
      @(negedge clk);
    end
    WE = 0;
  endtask

  // Checks one whole frame sample by sample; call right after the
  // write task returns (half a cycle after the capture edge).
  task automatic frame_chk(input string nm,
                           input logic [10:0] pat);
    logic [10:0] p;
    p = pat;
    for (int j = 0; j < FL; j++) begin
      @(negedge clk);
      chk(nm, {31'b0, tx}, {31'b0, p[j / CPB]});
    end
    @(negedge clk);
    chk({nm, "_idle"}, RD, 32'h0000_0001 | exp_par());
  endtask

  function automatic logic [31:0] exp_par();
`ifdef UART_PARITY_EN
    return 32'h10;
`else
    return 32'h0;
`endif
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 0;
    WE = 0;
    writedata = '0;
    repeat (2) @(negedge clk);
    chk("reset_RD", RD, 32'h0000_0001 | exp_par());
    chk("reset_tx", {31'b0, tx}, 32'h1);
    reset = 1;
    chk_en = 1;
    repeat (20) @(negedge clk);
    chk("idle_RD", RD, 32'h0000_0001 | exp_par());
    chk("idle_tx", {31'b0, tx}, 32'h1);

    // Single byte 0x55
    wr(32'h0000_0055);
    frame_chk("frame55", PAT55);

    // Upper bits of a data write ignored
    wr(32'h7FFF_FF55);
    frame_chk("frame55_hi", PAT55);

    // Overflow: six writes into a four-deep FIFO
    bv = '{32'h01, 32'h02, 32'h03, 32'h04, 32'h05, 32'h06};
    burst(6);
    chk("ovf_RD", RD, 32'h0000_040E | exp_par());

    wr(32'h8000_0001);
    chk("ovf_clr", RD, 32'h0000_0406 | exp_par());
    wr(32'h8000_0000);
    chk("ctrl_nop", RD, 32'h0000_0406 | exp_par());

    k = 0;
    while (RD !== (32'h1 | exp_par()) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("drain_done", {31'b0, k < 400}, 32'h1);

    // Parity cases (plain 8N1 frames when parity is off)
`ifdef UART_PARITY_EN
    wr(32'h0000_0007);
    frame_chk("par07", 11'b1_1_00000111_0);
    wr(32'h0000_0003);
    frame_chk("par03", 11'b1_0_00000011_0);
`else
    wr(32'h0000_0007);
    frame_chk("frame07", 11'b0_1_00000111_0);
`endif
    chk("par_flag", {31'b0, RD[4]}, exp_par() >> 4);

    // Reset in DATA bit 3 of 0xA5 with two bytes queued
    bv = '{32'hA5, 32'h11, 32'h22, 32'h0, 32'h0, 32'h0};
    burst(3);
    chk("mid_start", {31'b0, tx}, 32'h0);
    repeat (16) @(negedge clk);
    chk("mid_bit3", {31'b0, tx}, 32'h0);
    reset = 0;
    @(negedge clk);
    chk("mid_rst_tx", {31'b0, tx}, 32'h1);
    chk("mid_rst_RD", RD, 32'h0000_0001 | exp_par());
    reset = 1;
    repeat (100) @(negedge clk);
    chk("post_rst_tx", {31'b0, tx}, 32'h1);
    chk("post_rst_RD", RD, 32'h0000_0001 | exp_par());

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
